// File: rtl/fsm_input_seq_param.sv
// ---------------------------------------------------------------------------
// fsm_input_seq_param
//
// Operand-input enable sequencer for the FPU add/sub pipeline. A start request
// (init_OPERATION) opens a run window of SHIFT_CYCLES cycles during which the
// shift register is enabled. The operand input enable stays open for the first
// OPEN_CYCLES of that window. The block also provides busy/done status and a
// synchronous abort.
//
// Optional build macro: FSM_INPUT_SEQ_RETRIGGER_EN
//   When defined, a start request seen while the input window is closed is
//   remembered in a pending flag. On the last run cycle a pending or live
//   request restarts the run immediately, so there is no IDLE gap between
//   runs. When undefined, requests made during a run are ignored.
//
// Parameters:
//   SHIFT_CYCLES  run length in cycles          (1 .. 2^CNT_WIDTH-1)
//   OPEN_CYCLES   leading cycles with input open (0 .. SHIFT_CYCLES)
//   CNT_WIDTH     run counter width              (2^CNT_WIDTH > SHIFT_CYCLES)
//
// Ports:
//   clk                    in   system clock, rising edge
//   rst_n                  in   asynchronous active-low reset
//   init_OPERATION         in   start request, level-sensitive
//   abort                  in   synchronous cancel of the current run
//   enable_input_internal  out  operand-register input enable
//   enable_Pipeline_input  out  enable_input_internal & init_OPERATION
//   enable_shift_reg       out  shift-register enable (high during RUN)
//   busy                   out  high during RUN
//   done                   out  one-cycle registered pulse after a finished run
//   run_cnt                out  position inside the run window (debug)
// ---------------------------------------------------------------------------
module fsm_input_seq_param #(
    parameter int SHIFT_CYCLES = 5,
    parameter int OPEN_CYCLES  = 2,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_OPERATION,
    input  logic                 abort,
    output logic                 enable_input_internal,
    output logic                 enable_Pipeline_input,
    output logic                 enable_shift_reg,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] run_cnt
);

    // One-hot style encoding leaves two spare codes; both fall back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b01,
        RUN  = 2'b10
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(SHIFT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 in_run;
    logic                 is_open;
    logic                 last_cycle;

    // Input window decode. The zero-width window is handled separately so the
    // comparison never degenerates into an always-false unsigned compare.
    generate
        if (OPEN_CYCLES == 0) begin : g_never_open
            assign is_open = 1'b0;
        end else begin : g_open_cmp
            localparam logic [CNT_WIDTH-1:0] OPEN_CNT = CNT_WIDTH'(OPEN_CYCLES);
            assign is_open = (cnt_q < OPEN_CNT);
        end
    endgenerate

    assign in_run     = (state_q == RUN);
    assign last_cycle = in_run && (cnt_q == LAST_CNT);

`ifdef FSM_INPUT_SEQ_RETRIGGER_EN
    logic pending_q, pending_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef FSM_INPUT_SEQ_RETRIGGER_EN
        pending_d = pending_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef FSM_INPUT_SEQ_RETRIGGER_EN
                pending_d = 1'b0;
`endif
                if (init_OPERATION && !abort) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort wins over completion and retrigger; no done pulse.
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef FSM_INPUT_SEQ_RETRIGGER_EN
                    pending_d = 1'b0;
`endif
                end else if (last_cycle) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
`ifdef FSM_INPUT_SEQ_RETRIGGER_EN
                    pending_d = 1'b0;
                    if (pending_q || init_OPERATION) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
`ifdef FSM_INPUT_SEQ_RETRIGGER_EN
                    // Only requests the input window could not take are queued.
                    if (init_OPERATION && !is_open) begin
                        pending_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
`ifdef FSM_INPUT_SEQ_RETRIGGER_EN
                pending_d = 1'b0;
`endif
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef FSM_INPUT_SEQ_RETRIGGER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs: decoded from state/counter, no added latency. Spare encodings
    // present IDLE outputs for their single cycle.
    // -----------------------------------------------------------------------
    assign busy                  = in_run;
    assign enable_shift_reg      = in_run;
    assign enable_input_internal = !in_run || is_open;
    assign enable_Pipeline_input = enable_input_internal & init_OPERATION;
    assign done                  = done_q;
    assign run_cnt               = cnt_q;

endmodule

// File: doc/fsm_input_seq_param.md
Name: fsm_input_seq_param

Overview:
- Parametrised successor of the operand-input enable FSM for the FPU add/sub pipeline.
- On init_OPERATION it runs a shift-register enable window of SHIFT_CYCLES cycles.
- The operand input window stays open for the first OPEN_CYCLES of that window.
- Adds busy/done status, a synchronous abort and optional back-to-back retrigger, so the FPU interface can issue consecutive operations without idle gaps.

Parameters:
- SHIFT_CYCLES, 5, number of cycles enable_shift_reg is held high per operation (legal range 1 to 2^CNT_WIDTH-1).
- OPEN_CYCLES, 2, number of leading cycles of the run window in which enable_input_internal stays high (legal range 0 to SHIFT_CYCLES).
- CNT_WIDTH, 4, width of the run counter; must satisfy 2^CNT_WIDTH > SHIFT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- init_OPERATION  input  1  start request, level-sensitive
- abort  input  1  synchronous cancel of the current run
- enable_input_internal  output  1  operand-register input enable (intermediate)
- enable_Pipeline_input  output  1  first pipeline stage enable = enable_input_internal & init_OPERATION (combinational)
- enable_shift_reg  output  1  shift-register enable
- busy  output  1  high while in RUN
- done  output  1  one-cycle registered pulse after the last RUN cycle
- run_cnt  output  CNT_WIDTH  current position in the run window (debug)

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- While rst_n=0: state=IDLE, run_cnt=0, done=0, pending=0, busy=0, enable_shift_reg=0, enable_input_internal=1.
- enable_Pipeline_input follows init_OPERATION during reset and IDLE.
- States: IDLE and RUN. All outputs except done are decoded from state and run_cnt, with no extra latency.
- IDLE:
  - Outputs: enable_input_internal=1, enable_shift_reg=0, busy=0.
  - init_OPERATION=1 and abort=0 at a rising edge: go to RUN with run_cnt=0.
  - Otherwise stay in IDLE.
- RUN:
  - Outputs: enable_shift_reg=1, busy=1, enable_input_internal=(run_cnt < OPEN_CYCLES).
  - Each cycle run_cnt increments by 1.
  - At run_cnt=SHIFT_CYCLES-1: go to IDLE, run_cnt clears to 0, and done=1 on the next cycle.
- Latency: a start accepted at edge k gives RUN over cycles k+1 to k+SHIFT_CYCLES; done is high in cycle k+SHIFT_CYCLES+1.
- OPEN_CYCLES=0: enable_input_internal=0 for the whole run. OPEN_CYCLES=SHIFT_CYCLES: it stays 1 for the whole run.
- abort=1 in RUN: next state is IDLE, run_cnt=0, no done pulse, pending cleared.
  - abort has priority over completion and over retrigger.
- abort=1 in IDLE: blocks a start that cycle.
- Without the optional feature, init_OPERATION during RUN is ignored.
  - A level held high after completion restarts the sequence from IDLE on the following edge (one IDLE cycle between runs).
- run_cnt never exceeds SHIFT_CYCLES-1; wrap-around is impossible by construction.
- Unreachable state encodings recover to IDLE on the next edge.
- Reset asserted mid-run: immediate return to the reset values, no done pulse.

Optional Feature:
- Macro FSM_INPUT_SEQ_RETRIGGER_EN.
- When defined:
  - A pending flag is set by init_OPERATION=1 in any RUN cycle with run_cnt >= OPEN_CYCLES (closed window).
  - On the last RUN cycle, if pending=1 or init_OPERATION=1, the FSM stays in RUN with run_cnt=0 and clears pending.
  - done still pulses once for the finished run, giving back-to-back runs with no IDLE gap.
- When undefined: no pending register, behaviour exactly as above.

Test Plan:
- Reset, then init_OPERATION pulse for 1 cycle at edge k (defaults) -> RUN for k+1 to k+5; enable_input_internal 1,1,0,0,0; enable_shift_reg 1 for 5 cycles; done=1 only at k+6; busy=1 for k+1 to k+5.
- Idle with init_OPERATION toggling -> enable_Pipeline_input mirrors init_OPERATION; enable_shift_reg stays 0.
- abort=1 at run_cnt=3 -> IDLE next cycle, enable_shift_reg=0, no done pulse, busy=0.
- init_OPERATION held high continuously, macro undefined -> runs of 5 RUN cycles separated by exactly 1 IDLE cycle; done every 6 cycles.
- Macro defined, init pulse at run_cnt=3 -> second run starts immediately after run_cnt=4 (no IDLE); done pulses once per run.
- rst_n low at run_cnt=2, then released -> all outputs at reset values, run_cnt=0; a new init gives a normal 5-cycle run.
